// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch stage. Issues sequential or redirected fetch
// addresses to a pipelined, in-order instruction memory. Returned words are
// buffered in a small queue that feeds the IF/ID register. A redirect flushes
// the queue and marks every request still in flight as stale.
module if_prefetch_stage #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        if_valid,
  output logic [31:0] PC,
  output logic [31:0] if_pc4,
  output logic [31:0] if_Inst
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW        = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_EXT = DEPTH[CW:0];

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] side_rd_q, side_rd_d;
  logic [AW-1:0] side_wr_q, side_wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          post_rst_q, post_rst_d;

  // Prefetch queue storage and the PCs of live in-flight requests.
  logic [31:0]   q_pc_q    [DEPTH];
  logic [31:0]   q_inst_q  [DEPTH];
  logic [31:0]   side_pc_q [DEPTH];

  logic          queue_empty;
  logic          space_ok;
  logic          rsp_live;
  logic          push;
  logic          pop;

  // Issue decision, response classification and the IF/ID-facing outputs
  always_comb begin
    queue_empty = (count_q == {CW{1'b0}});
    // Reserving queue space for every in-flight request (stale ones included)
    // means a returning word always has a slot.
    space_ok    = ({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_EXT;
    im_req      = !Resetn && !post_rst_q && !redirect && space_ok;
    im_addr     = fetch_pc_q;
    if_valid    = !Resetn && !redirect && !queue_empty;
    if (Resetn) begin
      PC = RESET_PC;
    end else if (queue_empty) begin
      PC = fetch_pc_q;
    end else begin
      PC = q_pc_q[rd_ptr_q];
    end
    if_pc4 = PC + 32'd4;
    if (if_valid) begin
      if_Inst = q_inst_q[rd_ptr_q];
    end else begin
      if_Inst = 32'h0000_0000;
    end
    rsp_live = im_rvalid && (drop_cnt_q == {CW{1'b0}});
    push     = rsp_live && !redirect && !Resetn;
    pop      = if_valid && !stall;
  end

  // Next-state for the fetch address, queue/side-FIFO pointers and counters
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    side_rd_d  = side_rd_q;
    side_wr_d  = side_wr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    post_rst_d = 1'b0;

    case ({im_req, im_rvalid})
      2'b10:   outstanding_d = outstanding_q + CW'(1'b1);
      2'b01:   outstanding_d = outstanding_q - CW'(1'b1);
      default: outstanding_d = outstanding_q;
    endcase

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = {AW{1'b0}};
      wr_ptr_d   = {AW{1'b0}};
      side_rd_d  = {AW{1'b0}};
      side_wr_d  = {AW{1'b0}};
      count_d    = {CW{1'b0}};
      // No issue happens in a redirect cycle, so everything still in flight
      // after this edge belongs to the old path and must be discarded.
      drop_cnt_d = outstanding_d;
    end else begin
      if (im_req) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        side_wr_d  = side_wr_q + AW'(1'b1);
      end else begin
        fetch_pc_d = fetch_pc_q;
        side_wr_d  = side_wr_q;
      end
      if (push) begin
        wr_ptr_d  = wr_ptr_q + AW'(1'b1);
        side_rd_d = side_rd_q + AW'(1'b1);
      end else begin
        wr_ptr_d  = wr_ptr_q;
        side_rd_d = side_rd_q;
      end
      if (im_rvalid && !rsp_live) begin
        drop_cnt_d = drop_cnt_q - CW'(1'b1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous active-high reset
  always_ff @(posedge Clock) begin
    if (Resetn) begin
      fetch_pc_q    <= RESET_PC;
      rd_ptr_q      <= {AW{1'b0}};
      wr_ptr_q      <= {AW{1'b0}};
      side_rd_q     <= {AW{1'b0}};
      side_wr_q     <= {AW{1'b0}};
      count_q       <= {CW{1'b0}};
      outstanding_q <= {CW{1'b0}};
      drop_cnt_q    <= {CW{1'b0}};
      post_rst_q    <= 1'b1;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      side_rd_q     <= side_rd_d;
      side_wr_q     <= side_wr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      post_rst_q    <= post_rst_d;
    end
  end

  // Data storage; entries are qualified by the pointers so they need no reset
  always_ff @(posedge Clock) begin
    if (push) begin
      q_pc_q[wr_ptr_q]   <= side_pc_q[side_rd_q];
      q_inst_q[wr_ptr_q] <= im_rdata;
    end
    if (im_req) begin
      side_pc_q[side_wr_q] <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Self-checking bench for if_prefetch_stage. A queue-based model tracks the
// fetch address, the words waiting for ID and the requests held by a
// variable-latency in-order memory model.
module tb_if_prefetch_stage;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        Clock       = 1'b0;
  logic        Resetn      = 1'b1;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall       = 1'b0;
  logic        im_rvalid   = 1'b0;
  logic [31:0] im_rdata    = 32'h0;
  logic        im_req, if_valid;
  logic [31:0] im_addr, PC, if_pc4, if_Inst;

  always #5 Clock = ~Clock;

  if_prefetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .Clock(Clock), .Resetn(Resetn), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .im_req(im_req), .im_addr(im_addr), .im_rvalid(im_rvalid),
    .im_rdata(im_rdata), .if_valid(if_valid), .PC(PC), .if_pc4(if_pc4), .if_Inst(if_Inst)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t         mem_q[$];   // requests held by the memory, oldest first
  logic [31:0]  m_fifo[$];  // PCs of words waiting for ID, head first
  logic [31:0]  m_fetch = RESET_PC;
  bit           m_post  = 1'b0;
  int           cyc = 0, lat_min = 1, lat_max = 1;
  int           vectors = 0, miscompares = 0;
  bit           exp_req, exp_valid;
  logic [31:0]  exp_pc;
  logic [129:0] exp_v, obs_v;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Drive one cycle of inputs after the falling edge, then sample outputs.
  task automatic drive(input bit rst, input bit rd, input logic [31:0] rpc, input bit st);
    @(negedge Clock);
    Resetn = rst; redirect = rd; redirect_pc = rpc; stall = st;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      im_rvalid = 1'b1; im_rdata = mem_data(mem_q[0].addr);
    end else begin
      im_rvalid = 1'b0; im_rdata = $urandom;
    end
    exp_req   = !rst && !m_post && !rd && ((m_fifo.size() + mem_q.size()) < DEPTH);
    exp_valid = !rst && !rd && (m_fifo.size() > 0);
    exp_pc    = rst ? RESET_PC : ((m_fifo.size() > 0) ? m_fifo[0] : m_fetch);
    exp_v = {exp_req, exp_req ? m_fetch : 32'h0, exp_valid, exp_pc, exp_pc + 32'd4,
             exp_valid ? mem_data(exp_pc) : 32'h0};
    #1;
    obs_v = {im_req, im_req ? im_addr : 32'h0, if_valid, PC, if_pc4, if_Inst};
  endtask

  // Advance the model across the rising edge using the inputs just driven.
  task automatic commit();
    req_t h;
    req_t r;
    bit   got;
    int   due;
    @(posedge Clock);
    got = 1'b0;
    if (Resetn) begin
      m_fetch = RESET_PC; m_fifo.delete(); mem_q.delete(); m_post = 1'b1;
    end else begin
      m_post = 1'b0;
      if (im_rvalid) begin h = mem_q.pop_front(); got = 1'b1; end
      if (redirect) begin
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        m_fifo.delete();
        m_fetch = redirect_pc;
      end else begin
        if (exp_valid && !stall) void'(m_fifo.pop_front());
        if (got && !h.stale) m_fifo.push_back(h.addr);
        if (exp_req) begin
          due = cyc + int'($urandom_range(lat_max, lat_min));
          if (mem_q.size() > 0 && mem_q[$].due >= due) due = mem_q[$].due + 1;
          r.addr = m_fetch; r.due = due; r.stale = 1'b0;
          mem_q.push_back(r);
          m_fetch = m_fetch + 32'd4;
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    commit();
  endtask

  task automatic test_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 4; i++) begin
      drive(i < 2, 1'b0, 32'h0, 1'b0);
      vectors++;
      if (obs_v !== exp_v) begin miscompares++; $display("FAIL reset cyc=%0d got{req,addr,valid,pc,pc4,inst}=%h want=%h", cyc, obs_v, exp_v); end
      if (i == 2) begin
        vectors++;
        if (im_req !== 1'b0 || if_valid !== 1'b0 || PC !== RESET_PC || if_Inst !== 32'h0) begin
          miscompares++; $display("FAIL reset_hold got req=%b valid=%b pc=%h inst=%h want 0/0/%h/0", im_req, if_valid, PC, if_Inst, RESET_PC);
        end
      end
      if (i == 3) begin
        vectors++;
        if (im_req !== 1'b1 || im_addr !== RESET_PC) begin
          miscompares++; $display("FAIL first_issue got req=%b addr=%h want 1/%h", im_req, im_addr, RESET_PC);
        end
      end
      commit();
    end
  endtask

  task automatic test_stream();
    int first_req = -1, first_valid = -1, n_valid = 0;
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      vectors++;
      if (obs_v !== exp_v) begin miscompares++; $display("FAIL stream cyc=%0d got{req,addr,valid,pc,pc4,inst}=%h want=%h", cyc, obs_v, exp_v); end
      if (im_req === 1'b1 && first_req < 0) first_req = i;
      if (if_valid === 1'b1) begin
        n_valid++;
        if (first_valid < 0) begin
          first_valid = i;
          vectors++;
          if (PC !== 32'h0 || if_pc4 !== 32'h4 || if_Inst !== mem_data(32'h0)) begin
            miscompares++; $display("FAIL first_out got pc=%h pc4=%h inst=%h want 0/4/%h", PC, if_pc4, if_Inst, mem_data(32'h0));
          end
        end
      end
      commit();
    end
    vectors++;
    if (first_req != 1 || first_valid != 3 || n_valid != 17) begin
      miscompares++; $display("FAIL stream_timing got req@%0d valid@%0d n=%0d want 1/3/17", first_req, first_valid, n_valid);
    end
  endtask

  task automatic test_stall();
    int npop = 0;
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, 1'b0, 32'h0, (i >= 1 && i <= 8));
      vectors++;
      if (obs_v !== exp_v) begin miscompares++; $display("FAIL stall cyc=%0d got{req,addr,valid,pc,pc4,inst}=%h want=%h", cyc, obs_v, exp_v); end
      if (i == 8) begin
        vectors++;
        if (im_req !== 1'b0 || if_valid !== 1'b1 || PC !== 32'h0) begin
          miscompares++; $display("FAIL stall_full got req=%b valid=%b pc=%h want 0/1/0", im_req, if_valid, PC);
        end
      end
      if (if_valid === 1'b1 && !stall) begin
        vectors++;
        if (PC !== 32'(npop * 4)) begin
          miscompares++; $display("FAIL stall_order got pc=%h want %h", PC, 32'(npop * 4));
        end
        npop++;
      end
      commit();
    end
  endtask

  task automatic test_redirect();
    bit seen = 1'b0;
    lat_min = 3; lat_max = 3;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      drive(1'b0, (i == 3), 32'h40, 1'b0);
      vectors++;
      if (obs_v !== exp_v) begin miscompares++; $display("FAIL redirect cyc=%0d got{req,addr,valid,pc,pc4,inst}=%h want=%h", cyc, obs_v, exp_v); end
      if (i == 3) begin
        vectors++;
        if (if_valid !== 1'b0 || im_req !== 1'b0) begin
          miscompares++; $display("FAIL redirect_cycle got valid=%b req=%b want 0/0", if_valid, im_req);
        end
      end
      if (i > 3 && !seen && if_valid === 1'b1) begin
        seen = 1'b1;
        vectors++;
        if (PC !== 32'h40 || if_Inst !== mem_data(32'h40)) begin
          miscompares++; $display("FAIL redirect_first got pc=%h inst=%h want 40/%h", PC, if_Inst, mem_data(32'h40));
        end
      end
      commit();
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL redirect_timeout got no valid output want PC 40"); end
  endtask

  task automatic test_redirect_stall();
    int  rd_at = -1;
    bit  rd, st, seen = 1'b0;
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      rd = (rd_at < 0) && (m_fifo.size() == 3);
      st = (rd_at < 0) || (i == rd_at + 1);
      drive(1'b0, rd, 32'h100, st);
      vectors++;
      if (obs_v !== exp_v) begin miscompares++; $display("FAIL redir_stall cyc=%0d got{req,addr,valid,pc,pc4,inst}=%h want=%h", cyc, obs_v, exp_v); end
      if (rd) begin
        rd_at = i;
        vectors++;
        if (if_valid !== 1'b0 || if_Inst !== 32'h0) begin
          miscompares++; $display("FAIL redir_stall_cycle got valid=%b inst=%h want 0/0", if_valid, if_Inst);
        end
      end else if (rd_at >= 0 && i == rd_at + 1) begin
        vectors++;
        if (im_req !== 1'b1 || im_addr !== 32'h100 || if_valid !== 1'b0 || PC !== 32'h100) begin
          miscompares++; $display("FAIL redir_stall_after got req=%b addr=%h valid=%b pc=%h want 1/100/0/100", im_req, im_addr, if_valid, PC);
        end
      end else if (rd_at >= 0 && !seen && if_valid === 1'b1) begin
        seen = 1'b1;
        vectors++;
        if (PC !== 32'h100) begin miscompares++; $display("FAIL redir_stall_head got pc=%h want 100", PC); end
      end
      commit();
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL redir_stall_timeout got rd_at=%0d want a valid PC 100", rd_at); end
  endtask

  task automatic test_midreset();
    int rst_at = -1;
    bit rst;
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      rst = (rst_at < 0) && (m_fifo.size() == 2);
      drive(rst, 1'b0, 32'h0, (rst_at < 0));
      vectors++;
      if (obs_v !== exp_v) begin miscompares++; $display("FAIL midreset cyc=%0d got{req,addr,valid,pc,pc4,inst}=%h want=%h", cyc, obs_v, exp_v); end
      if (rst) rst_at = i;
      if (rst_at >= 0 && i == rst_at + 1) begin
        vectors++;
        if (if_valid !== 1'b0 || if_Inst !== 32'h0 || PC !== RESET_PC || im_req !== 1'b0) begin
          miscompares++; $display("FAIL midreset_hold got valid=%b inst=%h pc=%h req=%b want 0/0/%h/0", if_valid, if_Inst, PC, im_req, RESET_PC);
        end
      end
      if (rst_at >= 0 && i == rst_at + 2) begin
        vectors++;
        if (im_req !== 1'b1 || im_addr !== RESET_PC) begin
          miscompares++; $display("FAIL midreset_restart got req=%b addr=%h want 1/%h", im_req, im_addr, RESET_PC);
        end
      end
      commit();
    end
    vectors++;
    if (rst_at < 0) begin miscompares++; $display("FAIL midreset_timeout got no 2-entry queue want reset applied"); end
  endtask

  task automatic test_wrap();
    logic [31:0] want [3];
    int          nreq = 0;
    bit          seen = 1'b0;
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, (i == 0), 32'hFFFF_FFF8, 1'b0);
      vectors++;
      if (obs_v !== exp_v) begin miscompares++; $display("FAIL wrap cyc=%0d got{req,addr,valid,pc,pc4,inst}=%h want=%h", cyc, obs_v, exp_v); end
      if (i > 0 && im_req === 1'b1 && nreq < 3) begin
        vectors++;
        if (im_addr !== want[nreq]) begin
          miscompares++; $display("FAIL wrap_addr got %h want %h", im_addr, want[nreq]);
        end
        nreq++;
      end
      if (if_valid === 1'b1 && PC === 32'hFFFF_FFFC) begin
        seen = 1'b1;
        vectors++;
        if (if_pc4 !== 32'h0) begin miscompares++; $display("FAIL wrap_pc4 got %h want 00000000", if_pc4); end
      end
      commit();
    end
    vectors++;
    if (!seen || nreq != 3) begin miscompares++; $display("FAIL wrap_timeout got seen=%b nreq=%0d want 1/3", seen, nreq); end
  endtask

  task automatic test_random();
    bit          rst, rd, st;
    logic [31:0] rpc;
    lat_min = 1; lat_max = 4;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(99, 0) == 0);
      rd  = ($urandom_range(99, 0) < 10);
      st  = ($urandom_range(99, 0) < 30);
      rpc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      drive(rst, rd, rpc, st);
      vectors++;
      if (obs_v !== exp_v) begin miscompares++; $display("FAIL random cyc=%0d got{req,addr,valid,pc,pc4,inst}=%h want=%h", cyc, obs_v, exp_v); end
      commit();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_midreset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
Instruction-fetch front end that feeds the IF/ID pipeline register. It generates sequential and redirected fetch addresses and issues them to a pipelined instruction memory with variable latency and in-order responses. Returned instructions are buffered in a small prefetch queue and presented as {PC, if_pc4, if_Inst, if_valid}. Branch/jump redirects flush the queue and discard stale in-flight responses; stalls from the hazard logic hold the queue head.

Parameters:
DEPTH, 4, prefetch queue entries; power of 2, minimum 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  synchronous, active-high reset (name kept for codebase consistency; asserted = 1)
redirect  in  1  branch/jump taken this cycle (pcsource 01/10 from ID)
redirect_pc  in  32  target address (bpc or jpc)
stall  in  1  downstream cannot accept the head this cycle
im_req  out  1  instruction-memory request strobe
im_addr  out  32  request address (word aligned)
im_rvalid  in  1  response valid; responses are in request order, latency ≥1
im_rdata  in  32  response instruction word
if_valid  out  1  head entry valid and not flushed
PC  out  32  head entry address; fetch_pc when queue empty
if_pc4  out  32  PC + 4 (mod 2^32)
if_Inst  out  32  head instruction; 32'h0 (NOP bubble) when if_valid=0

Behaviour:
- State: fetch_pc[31:0]; queue of DEPTH {pc, inst} entries; rd_ptr/wr_ptr mod DEPTH; count 0..DEPTH; outstanding 0..DEPTH; drop_cnt 0..DEPTH.
- Reset (Resetn=1 at edge): fetch_pc=RESET_PC, queue empty, outstanding=drop_cnt=0. During the reset cycle and the following cycle: im_req=0, if_valid=0, if_Inst=0, PC=RESET_PC, if_pc4=RESET_PC+4. Instruction memory is reset in the same cycle, so no pre-reset responses arrive afterwards.
- Issue rule: im_req=1 iff !Resetn && !redirect && (count + outstanding) < DEPTH. im_addr=fetch_pc. On issue, fetch_pc <= fetch_pc+4, wrapping 32'hFFFF_FFFC -> 0. This space reservation guarantees the queue never overflows.
- Outstanding: outstanding <= outstanding + im_req - im_rvalid.
- Response handling: if im_rvalid && drop_cnt>0, discard the response and decrement drop_cnt. Otherwise write {pc of oldest live request, im_rdata} at wr_ptr. Request PCs are tracked in a DEPTH-deep side FIFO. A written entry is visible the next cycle, with no bypass. With 1-cycle memory, a request in cycle t gives if_valid in cycle t+2.
- Pop: when if_valid && !stall, the head retires at the edge. Push and pop in the same cycle leave count unchanged, including when count=DEPTH.
- Redirect (priority over stall and pop):
  - if_valid is forced 0 combinationally in the redirect cycle.
  - At the edge: queue flushed (count=0, pointers reset), fetch_pc <= redirect_pc, drop_cnt <= outstanding - im_rvalid_live (all surviving in-flight requests become stale), PC-tracking FIFO cleared.
  - Any response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle; the first request to redirect_pc goes out the next cycle.
- Back-to-back redirects: each one re-flushes; drop_cnt accumulates correctly.
- Stall with an empty queue has no effect. Stall never blocks issue except through the space rule.
- Output invariant: if_Inst=32'h0 and if_valid=0 whenever the queue is empty, in reset, or in a redirect cycle.

Test Plan:
1. Release reset with 1-cycle memory and stall=0 -> im_addr 0,4,8,… on consecutive cycles. First if_valid 2 cycles after the first im_req with PC=0, if_pc4=4. Then one instruction per cycle in order.
2. Hold stall high for 8 cycles with a streaming 1-cycle memory -> count reaches 4 and im_req drops once count+outstanding=4. After release, PCs 0x0..0xC appear in order with none lost or duplicated, then fetch resumes at 0x10.
3. 3-cycle memory with 2 outstanding; pulse redirect with redirect_pc=0x40 -> if_valid=0 that cycle; the next 2 responses are dropped. First valid output is PC=0x40 with the data returned for im_addr 0x40.
4. redirect=1 and stall=1 together while the queue holds 3 entries -> queue flushed and next fetch at redirect_pc; stall does not preserve the old head.
5. Assert Resetn mid-stream with 2 entries queued -> next cycle if_valid=0, if_Inst=0, PC=RESET_PC, im_req=0; fetch restarts at RESET_PC.
6. redirect_pc=32'hFFFF_FFF8 with stall=0 -> requests 0xFFFFFFF8, 0xFFFFFFFC, 0x0. if_pc4 for the 0xFFFFFFFC entry is 0x0.
